seq_muldiv: RTL and testbench
=============================

SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values: even, 8..64.
REQ-002 SHALL have parameter FAST_ZERO, default 1; 1 = divide-by-zero and reserved ops complete without iteration.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  unit can accept a request.
REQ-008 SHALL have port op  input  3  operation code: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved.
REQ-009 SHALL have port in1  input  WIDTH  multiplicand / dividend.
REQ-010 SHALL have port in2  input  WIDTH  multiplier / divisor.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out  output  WIDTH  result.
REQ-014 SHALL have port zero  output  1  out == 0.
REQ-015 SHALL have port neg  output  1  out[WIDTH-1].

Function
REQ-016 SHALL implement states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL accept a request on the rising edge where in_valid && in_ready; op, in1, in2 are captured there and later input changes have no effect.
REQ-018 SHALL go IDLE->CALC on acceptance, remain in CALC exactly WIDTH cycles (one radix-2 step per cycle), then enter DONE; out_valid first high WIDTH+1 cycles after the acceptance edge.
REQ-019 SHALL use shift-add for MUL/MULH/MULHU: MUL = low WIDTH bits of the product; MULH = high WIDTH bits of the signed*signed product; MULHU = high WIDTH bits of the unsigned*unsigned product.
REQ-020 SHALL use restoring division on magnitudes for DIV/MOD: quotient truncated toward zero; remainder takes the sign of the dividend; DIVU/MODU are unsigned.
REQ-021 SHALL return, on divisor == 0: DIV/DIVU all-ones, MOD/MODU = in1; with FAST_ZERO=1 the unit goes IDLE->DONE directly (out_valid 1 cycle after acceptance).
REQ-022 SHALL return, for signed overflow (in1 = most-negative, in2 = -1): DIV = in1, MOD = 0, after full WIDTH-cycle latency.
REQ-023 SHALL return out = 0 for op 7, with the same timing as REQ-021.
REQ-024 SHALL hold out, zero and neg stable throughout DONE until out_valid && out_ready; that edge returns the unit to IDLE.
REQ-025 SHALL accept no new request in the cycle a result is consumed (no bypass); the earliest next acceptance is one cycle later.
REQ-026 SHALL, when flush = 1, go to IDLE on that edge from any state, discard partial and held results, and ignore in_valid on that edge.
REQ-027 SHALL give rst priority over flush, and flush priority over handshakes.
REQ-028 SHALL keep out, zero and neg at their last values outside DONE; they are valid only while out_valid = 1.

Reset
REQ-029 SHALL, on rst, enter IDLE with in_ready = 1, out_valid = 0, out = 0, zero = 1, neg = 0, and clear all internal registers, including mid-operation.
REQ-030 SHALL ignore in_valid on a rst edge; the first acceptance is possible on the edge after rst deasserts.

Verification (WIDTH=32 unless noted)
REQ-031 SHALL cover: DIV 7/3, out_ready=1 -> out=2, out_valid exactly 33 cycles after acceptance; MOD 7/3 -> 1; DIV -7/2 -> 0xFFFFFFFD; MOD -7/2 -> 0xFFFFFFFF, neg=1.
REQ-032 SHALL cover: MUL 0x7FFFFFFF*2 -> 0xFFFFFFFE, neg=1; MULH 0xFFFFFFF8*3 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL 0*5 -> 0, zero=1.
REQ-033 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF after 1 cycle; MODU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; MOD of the same -> 0.
REQ-034 SHALL cover backpressure: out_ready low for 10 cycles in DONE -> out held constant, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-035 SHALL cover flush at cycle 10 of CALC -> IDLE next edge, out_valid never asserted; the following DIVU 100/7 -> 14 with normal latency.
REQ-036 SHALL cover rst mid-CALC and a WIDTH=8 build: MUL 0x10*0x10 -> 0x00, MULHU -> 0x01, latency 9.

Source files
------------

// File: rtl/seq_muldiv.sv
// seq_muldiv: sequential integer multiply/divide unit, one radix-2 step per clock.
//
// Multiplies use shift-add on operand magnitudes; divides use restoring
// division on magnitudes. Signs are re-applied on the final step so that the
// result is registered on the same edge the unit enters DONE.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   flush      synchronous abort of any in-flight or held operation
//   in_valid   request valid          in_ready   unit is IDLE and can accept
//   op         0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved
//   in1, in2   multiplicand/dividend, multiplier/divisor
//   out_valid  result valid (DONE)   out_ready  consumer accepts the result
//   out        result                zero/neg   out == 0 / out[WIDTH-1]
module seq_muldiv #(
  parameter int WIDTH     = 32,
  parameter int FAST_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;
  localparam logic [2:0] OP_MODU  = 3'd6;
  localparam logic [2:0] OP_RSV   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement negate when n is set; doubles as |v| when n is the sign.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic n);
    logic [WIDTH-1:0] r;
    if (n) begin
      r = ~v + WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic is_div_op(input logic [2:0] o);
    return (o >= OP_DIV) && (o <= OP_MODU);
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {partial product | remainder, multiplier | quotient}
  logic               res_neg_q, res_neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;

  logic               s1, s2, div_zero, fast_op;
  logic [WIDTH-1:0]   a_init, fast_value;
  logic [2*WIDTH-1:0] acc_init;
  logic               res_neg_init;

  logic [WIDTH:0]     mul_sum, div_rp, div_diff;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_hi, step_lo, result;

  // Operand preparation for a request presented on the inputs.
  always_comb begin
    s1       = in1[WIDTH-1];
    s2       = in2[WIDTH-1];
    div_zero = (in2 == {WIDTH{1'b0}});
    fast_op  = (op == OP_RSV) || (is_div_op(op) && div_zero);
    case (op)
      OP_MUL, OP_MULHU: begin
        a_init       = in1;
        acc_init     = {{WIDTH{1'b0}}, in2};
        res_neg_init = 1'b0;
      end
      OP_MULH: begin
        a_init       = cond_negate(in1, s1);
        acc_init     = {{WIDTH{1'b0}}, cond_negate(in2, s2)};
        res_neg_init = s1 ^ s2;
      end
      OP_DIV: begin
        a_init       = cond_negate(in2, s2);
        acc_init     = {{WIDTH{1'b0}}, cond_negate(in1, s1)};
        // all-ones quotient on a zero divisor must not be sign-flipped
        res_neg_init = (s1 ^ s2) & ~div_zero;
      end
      OP_MOD: begin
        a_init       = cond_negate(in2, s2);
        acc_init     = {{WIDTH{1'b0}}, cond_negate(in1, s1)};
        res_neg_init = s1;
      end
      OP_DIVU, OP_MODU: begin
        a_init       = in2;
        acc_init     = {{WIDTH{1'b0}}, in1};
        res_neg_init = 1'b0;
      end
      default: begin
        a_init       = {WIDTH{1'b0}};
        acc_init     = {(2*WIDTH){1'b0}};
        res_neg_init = 1'b0;
      end
    endcase
    case (op)
      OP_DIV, OP_DIVU: fast_value = {WIDTH{1'b1}};
      OP_MOD, OP_MODU: fast_value = in1;
      default:         fast_value = {WIDTH{1'b0}};
    endcase
  end

  // One radix-2 step: shift-add for multiplies, restoring subtract for divides.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_rp   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_rp - {1'b0, a_q};
    if (op_q <= OP_MULHU) begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      // remainder < divisor always fits WIDTH bits after a successful subtract
      step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = {div_rp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final result selection with sign re-application, using the last step's value.
  always_comb begin
    step_hi = step_acc[2*WIDTH-1:WIDTH];
    step_lo = step_acc[WIDTH-1:0];
    case (op_q)
      OP_MUL: result = step_lo;
      OP_MULH: begin
        // high half of the negated 2*WIDTH product: ~hi plus the carry out of ~lo + 1
        if (res_neg_q) begin
          result = ~step_hi + {{(WIDTH-1){1'b0}}, (step_lo == {WIDTH{1'b0}})};
        end else begin
          result = step_hi;
        end
      end
      OP_MULHU:        result = step_hi;
      OP_DIV, OP_DIVU: result = cond_negate(step_lo, res_neg_q);
      OP_MOD, OP_MODU: result = cond_negate(step_hi, res_neg_q);
      default:         result = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and datapath register update; flush overrides any handshake.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    acc_d     = acc_q;
    res_neg_d = res_neg_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d      = op;
          a_d       = a_init;
          acc_d     = acc_init;
          res_neg_d = res_neg_init;
          cnt_d     = {CW{1'b0}};
          if ((FAST_ZERO != 0) && fast_op) begin
            state_d = DONE;
            out_d   = fast_value;
            zero_d  = (fast_value == {WIDTH{1'b0}});
            neg_d   = fast_value[WIDTH-1];
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = step_acc;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          out_d   = result;
          zero_d  = (result == {WIDTH{1'b0}});
          neg_d   = result[WIDTH-1];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      // out/zero/neg keep their last values; only the operation is discarded
      state_d   = IDLE;
      op_d      = 3'd0;
      a_d       = {WIDTH{1'b0}};
      acc_d     = {(2*WIDTH){1'b0}};
      res_neg_d = 1'b0;
      cnt_d     = {CW{1'b0}};
    end else begin
      state_d = state_d;
    end
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      a_q         <= {WIDTH{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      res_neg_q   <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= {WIDTH{1'b0}};
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      res_neg_q   <= res_neg_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Testbench for seq_muldiv: WIDTH=32 and WIDTH=8 instances checked against an
// arithmetic reference model (plain integer multiply/divide on 64-bit values).
module tb_seq_muldiv;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        out_ready;

  logic        in_valid, in_ready, out_valid, zero, neg;
  logic [2:0]  op;
  logic [31:0] in1, in2, out;

  logic       in_valid8, in_ready8, out_valid8, zero8, neg8;
  logic [2:0] op8;
  logic [7:0] in1_8, in2_8, out8;

  int n_tests = 0;
  int n_fail  = 0;

  seq_muldiv #(.WIDTH(32), .FAST_ZERO(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .neg(neg)
  );

  seq_muldiv #(.WIDTH(8), .FAST_ZERO(1)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .in1(in1_8), .in2(in2_8), .out_valid(out_valid8), .out_ready(out_ready),
    .out(out8), .zero(zero8), .neg(neg8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on w-bit values held in 64 bits.
  function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, r;
    longint sa, sb, sp;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    case (o)
      3'd0: r = a * b;
      3'd1: begin sp = sa * sb; r = 64'(sp >>> w); end
      3'd2: r = (a * b) >> w;
      3'd3: r = (b == 64'd0) ? mask : 64'(sa / sb);
      3'd4: r = (b == 64'd0) ? mask : a / b;
      3'd5: r = (b == 64'd0) ? a : 64'(sa % sb);
      3'd6: r = (b == 64'd0) ? a : a % b;
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  function automatic int exp_latency(input int w, input logic [2:0] o, input logic [63:0] b);
    if (o == 3'd7 || (o >= 3'd3 && o <= 3'd6 && b == 64'd0)) return 1;
    return w + 1;
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    // later input changes must not affect the captured operation
    in_valid = 1'b0; op = 3'($urandom_range(7, 0)); in1 = $urandom; in2 = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic do_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic n, output int lat);
    out_ready = 1'b1;
    start_op(o, a, b);
    wait_valid(lat);
    r = out; z = zero; n = neg;
    @(posedge clk); #1;
  endtask

  task automatic do_txn8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic z, output int lat);
    int guard = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (!in_ready8 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    op8 = o; in1_8 = a; in2_8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; in1_8 = 8'($urandom); in2_8 = 8'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid8) break;
    end
    if (!out_valid8) lat = -1;
    r = out8; z = zero8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd0; in1 = 32'd5; in2 = 32'd3;
    in_valid8 = 1'b0; op8 = 3'd0; in1_8 = 8'd0; in2_8 = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'd0 || zero !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b out=%h zero=%b neg=%b, want 1 0 00000000 1 0",
               in_ready, out_valid, out, zero, neg);
    end
    n_tests++;
    if (in_ready8 !== 1'b1 || out8 !== 8'd0 || zero8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state8: rdy=%b out=%h zero=%b, want 1 00 1", in_ready8, out8, zero8);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ignores_valid: in_ready=%b want 1", in_ready);
    end
  endtask

  logic [2:0]  d_op  [15] = '{3'd3, 3'd5, 3'd3, 3'd5, 3'd0, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6,
                              3'd3, 3'd5, 3'd7, 3'd3, 3'd5};
  logic [31:0] d_a   [15] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7FFFFFFF,
                              32'hFFFFFFF8, 32'hFFFFFFFF, 32'd0, 32'd5, 32'd5,
                              32'h80000000, 32'h80000000, 32'd1, 32'hFFFFFFF9, 32'hFFFFFFF9};
  logic [31:0] d_b   [15] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd2, 32'd3, 32'hFFFFFFFF, 32'd5,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0};
  logic [31:0] d_exp [15] = '{32'd2, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFE,
                              32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd5,
                              32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
  int          d_lat [15] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 33, 33, 1, 1, 1};

  task automatic test_directed;
    logic [31:0] r, e;
    logic z, n;
    int lat;
    for (int i = 0; i < 15; i++) begin
      do_txn(d_op[i], d_a[i], d_b[i], r, z, n, lat);
      e = d_exp[i];
      n_tests++;
      if (r !== e) begin
        n_fail++;
        $display("FAIL directed_out[%0d]: got %h want %h", i, r, e);
      end
      n_tests++;
      if (lat !== d_lat[i]) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, d_lat[i]);
      end
      n_tests++;
      if (z !== (e == 32'd0) || n !== e[31]) begin
        n_fail++;
        $display("FAIL directed_flags[%0d]: zero=%b neg=%b want %b %b", i, z, n, (e == 32'd0), e[31]);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b, r, e;
    logic z, n;
    int lat, el;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(7, 0));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7, 0))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(1000, 0); b = $urandom_range(20, 1); end
        default: b = b >> $urandom_range(31, 0);
      endcase
      e  = 32'(model(32, o, {32'd0, a}, {32'd0, b}));
      el = exp_latency(32, o, {32'd0, b});
      do_txn(o, a, b, r, z, n, lat);
      n_tests++;
      if (r !== e || lat !== el) begin
        n_fail++;
        $display("FAIL random[%0d] op%0d %h,%h: got %h lat %0d want %h lat %0d", i, o, a, b, r, lat, e, el);
      end
      n_tests++;
      if (z !== (e == 32'd0) || n !== e[31]) begin
        n_fail++;
        $display("FAIL random_flags[%0d]: zero=%b neg=%b want %b %b", i, z, n, (e == 32'd0), e[31]);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    start_op(3'd4, 32'd1000, 32'd7);
    wait_valid(lat);
    n_tests++;
    if (out !== 32'd142 || lat !== 33) begin
      n_fail++;
      $display("FAIL bp_result: got %h lat %0d want 0000008e lat 33", out, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(1, 0)); op = 3'd0; in1 = $urandom; in2 = $urandom;
      @(negedge clk);
      n_tests++;
      if (out !== 32'd142 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out=%h vld=%b rdy=%b want 0000008e 1 0", i, out, out_valid, in_ready);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; in1 = 32'd3; in2 = 32'd4;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom;
    wait_valid(lat);
    n_tests++;
    if (out !== 32'd12 || lat !== 33) begin
      n_fail++;
      $display("FAIL bp_next: got %h lat %0d want 0000000c lat 33", out, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    logic [31:0] r;
    logic z, n;
    int lat;
    bit seen;
    out_ready = 1'b1;
    start_op(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; in1 = 32'd2; in2 = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_valid: out_valid seen=%b want 0", seen);
    end
    do_txn(3'd4, 32'd100, 32'd7, r, z, n, lat);
    n_tests++;
    if (r !== 32'd14 || lat !== 33) begin
      n_fail++;
      $display("FAIL flush_next: got %h lat %0d want 0000000e lat 33", r, lat);
    end
  endtask

  task automatic test_rst_mid;
    logic [31:0] r;
    logic z, n;
    int lat;
    bit seen;
    start_op(3'd2, $urandom, $urandom);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; op = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'd0 || zero !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: rdy=%b vld=%b out=%h zero=%b neg=%b, want 1 0 00000000 1 0",
               in_ready, out_valid, out, zero, neg);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_no_valid: out_valid seen=%b want 0", seen);
    end
    do_txn(3'd0, 32'd6, 32'd7, r, z, n, lat);
    n_tests++;
    if (r !== 32'd42 || lat !== 33) begin
      n_fail++;
      $display("FAIL rst_mid_next: got %h lat %0d want 0000002a lat 33", r, lat);
    end
  endtask

  task automatic test_width8;
    logic [2:0] o;
    logic [7:0] a, b, r, e;
    logic z;
    int lat, el;
    do_txn8(3'd0, 8'h10, 8'h10, r, z, lat);
    n_tests++;
    if (r !== 8'h00 || z !== 1'b1 || lat !== 9) begin
      n_fail++;
      $display("FAIL w8_mul: got %h zero=%b lat %0d want 00 1 lat 9", r, z, lat);
    end
    do_txn8(3'd2, 8'h10, 8'h10, r, z, lat);
    n_tests++;
    if (r !== 8'h01 || lat !== 9) begin
      n_fail++;
      $display("FAIL w8_mulhu: got %h lat %0d want 01 lat 9", r, lat);
    end
    for (int i = 0; i < 20; i++) begin
      o = 3'($urandom_range(7, 0));
      a = 8'($urandom);
      b = ($urandom_range(5, 0) == 0) ? 8'd0 : 8'($urandom);
      e  = 8'(model(8, o, {56'd0, a}, {56'd0, b}));
      el = exp_latency(8, o, {56'd0, b});
      do_txn8(o, a, b, r, z, lat);
      n_tests++;
      if (r !== e || lat !== el) begin
        n_fail++;
        $display("FAIL w8_random[%0d] op%0d %h,%h: got %h lat %0d want %h lat %0d", i, o, a, b, r, lat, e, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
